spi_cmd_slave: RTL and testbench
================================

SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth for sclk/cs_n/mosi into clk domain (legal 2..3).
REQ-002 Parameter: RD_TIMEOUT, 16, max clk cycles from rd_req to rd_valid before the read is declared timed out.
REQ-003 Port: clk  in  1  system clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Ports: sclk, cs_n, mosi  in  1 each  SPI mode 0 from external master (cs_n active low).
REQ-006 Port: miso  out  1  SPI read data, MSB first.
REQ-007 Ports: wr_valid  out  1; start  out  1; rd_req  out  1  single-clk pulses to NPU core.
REQ-008 Ports: tile_i, tile_j, op_code  out  3 each  decoded address/op, held stable from pulse until next frame decode.
REQ-009 Port: wr_data  out  8  write payload, valid with wr_valid.
REQ-010 Ports: rd_valid  in  1; rd_data  in  8  core read response.
REQ-011 Port: done  in  1  core completion level, reported by STATUS command.
REQ-012 Port: frame_err  out  1  sticky; set on short frame, unknown cmd or read timeout; cleared by STATUS read.

Function
REQ-013 sclk, cs_n, mosi SHALL pass through SYNC_STAGES flops; edges detected in clk domain; clk SHALL be >= 4x sclk (bench constraint).
REQ-014 Frame = 32 bits MSB first while cs_n low: [31:24] cmd, [23:21] tile_i, [20:18] tile_j, [17:15] op_code, [14:8] pad (turnaround, ignored), [7:0] data.
REQ-015 mosi sampled on each synchronized sclk rising edge; miso updated on each synchronized sclk falling edge.
REQ-016 FSM states: IDLE, HDR (bits 31..15), PAD (bits 14..8), DATA (bits 7..0), DONE; cs_n falling edge IDLE->HDR with bit counter = 31.
REQ-017 After bit 15 sampled: tile_i/tile_j/op_code latched; if cmd==0x03 (READ) or 0x04 (STATUS) rd path armed; READ pulses rd_req next clk.
REQ-018 READ: first rd_valid within RD_TIMEOUT clks after rd_req latches rd_data into tx shift reg; later rd_valid pulses ignored.
REQ-019 READ timeout: tx shift reg loaded 0xEE, frame_err set.
REQ-020 STATUS: tx shift reg loaded {6'b0, frame_err, done} at bit 15.
REQ-021 miso SHALL drive tx bit 7 on first falling edge after bit 8 sampled, then bits 6..0 on successive falling edges; miso = 0 at all other times, including cs_n high.
REQ-022 After bit 0 sampled (counter wrap 0): cmd 0x01 (WRITE) pulses wr_valid with wr_data = data; cmd 0x02 (START) pulses start; READ/STATUS no pulse; any other cmd -> frame_err set, no pulse.
REQ-023 Pulse SHALL occur within 2 clks of synchronized bit-0 sclk rise and last exactly 1 clk.
REQ-024 cs_n rising before bit 0 sampled: frame discarded, no pulse, frame_err set, FSM -> IDLE; rd_req already issued is not retracted.
REQ-025 Bits beyond 32 while cs_n low ignored; FSM stays DONE until cs_n rises, then IDLE.
REQ-026 cs_n falling in same clk as a DONE->IDLE transition SHALL start a new frame (no frame lost back-to-back).
REQ-027 STATUS read clears frame_err at bit 0 sampling; an error event in that same clk wins (stays set).

Reset
REQ-028 rst_n low SHALL asynchronously force: FSM IDLE, counter 31, miso 0, wr_valid/start/rd_req 0, tile_i/tile_j/op_code/wr_data 0, frame_err 0, synchronizers to idle levels (sclk 0, cs_n 1, mosi 0).
REQ-029 Reset asserted mid-frame SHALL drop the frame with no pulse; first frame after release SHALL require a fresh cs_n falling edge.

Verification
REQ-030 WRITE 0x01, tile (2,5), op 3, data 0xA7 -> one wr_valid pulse, tile_i=2, tile_j=5, op_code=3, wr_data=0xA7, frame_err=0.
REQ-031 READ 0x03, tile (7,0), core answers rd_data=0x3C 5 clks after rd_req -> master shifts in 0x3C; exactly one rd_req pulse.
REQ-032 READ with rd_valid never asserted -> master receives 0xEE; subsequent STATUS with done=1 returns 0x03 and then frame_err=0.
REQ-033 cs_n deasserted after 20 bits of WRITE frame -> no wr_valid, frame_err=1; next full START frame produces one start pulse.
REQ-034 Unknown cmd 0x7F -> no pulses, frame_err=1; miso stays 0 throughout.
REQ-035 rst_n asserted at bit 10 of a WRITE frame, released, then full 64-frame WRITE burst back-to-back -> exactly 64 wr_valid pulses, none for the aborted frame.

Source files
------------

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: decodes 32-bit MSB-first frames into single-cycle
// write/start/read requests for the NPU core and returns read/status bytes on miso.
module spi_cmd_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       wr_valid,
    output logic       start,
    output logic       rd_req,
    output logic [2:0] tile_i,
    output logic [2:0] tile_j,
    output logic [2:0] op_code,
    output logic [7:0] wr_data,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    input  logic       done,
    output logic       frame_err
);

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_START  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;
    localparam int unsigned RCW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, HDR, PAD, DATA, DONE} state_e;

    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic                   sclkPrev_q;
    logic                   csPrev_q;

    state_e         state_q;
    logic [4:0]     bitCnt_q;
    logic [15:0]    rxShift_q;
    logic [7:0]     cmd_q;
    logic [7:0]     txShift_q;
    logic           miso_q;
    logic           wrValid_q;
    logic           start_q;
    logic           rdReq_q;
    logic [2:0]     tileI_q;
    logic [2:0]     tileJ_q;
    logic [2:0]     opCode_q;
    logic [7:0]     wrData_q;
    logic           frameErr_q;
    logic           frameErr_d;
    logic           rdWait_q;
    logic [RCW-1:0] rdCnt_q;

    logic        sclkS;
    logic        csS;
    logic        mosiS;
    logic        sclkRise;
    logic        sclkFall;
    logic        csRise;
    logic        csFall;
    logic [15:0] rxNext;
    logic        lastBitEvt;
    logic        abortEvt;
    logic        unknownEvt;
    logic        statusClr;
    logic        rdTimeout;
    logic        misoHold;

    // Idle levels on reset keep a spurious edge from appearing as the chain fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            sclkPrev_q <= 1'b0;
            csPrev_q   <= 1'b1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_n};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
            csPrev_q   <= csSync_q[SYNC_STAGES-1];
        end
    end

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign csS      = csSync_q[SYNC_STAGES-1];
    assign mosiS    = mosiSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign sclkFall = ~sclkS & sclkPrev_q;
    assign csRise   = csS & ~csPrev_q;
    assign csFall   = ~csS & csPrev_q;
    assign rxNext   = {rxShift_q[14:0], mosiS};

    // A bit-0 sample arriving with cs_n rise in the same clk completes the frame.
    assign lastBitEvt = (state_q == DATA) && sclkRise && (bitCnt_q == 5'd0);
    assign abortEvt   = csRise && !lastBitEvt &&
                        ((state_q == HDR) || (state_q == PAD) || (state_q == DATA));
    assign unknownEvt = lastBitEvt && (cmd_q != CMD_WRITE) && (cmd_q != CMD_START) &&
                        (cmd_q != CMD_READ) && (cmd_q != CMD_STATUS);
    assign statusClr  = lastBitEvt && (cmd_q == CMD_STATUS);
    assign rdTimeout  = rdWait_q && !rd_valid && (rdCnt_q == RCW'(RD_TIMEOUT - 1));
    assign frameErr_d = (frameErr_q & ~statusClr) | abortEvt | unknownEvt | rdTimeout;
    assign misoHold   = (state_q == DATA) || ((state_q == DONE) && !sclkFall && !csS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitCnt_q   <= 5'd31;
            rxShift_q  <= '0;
            cmd_q      <= '0;
            txShift_q  <= '0;
            miso_q     <= 1'b0;
            wrValid_q  <= 1'b0;
            start_q    <= 1'b0;
            rdReq_q    <= 1'b0;
            tileI_q    <= '0;
            tileJ_q    <= '0;
            opCode_q   <= '0;
            wrData_q   <= '0;
            frameErr_q <= 1'b0;
            rdWait_q   <= 1'b0;
            rdCnt_q    <= '0;
        end else begin
            wrValid_q  <= 1'b0;
            start_q    <= 1'b0;
            rdReq_q    <= 1'b0;
            frameErr_q <= frameErr_d;
            if (!misoHold) begin
                miso_q <= 1'b0;
            end

            // Only the first core response (or the timeout filler) reaches the tx byte.
            if (rdWait_q) begin
                if (rd_valid) begin
                    txShift_q <= rd_data;
                    rdWait_q  <= 1'b0;
                end else if (rdTimeout) begin
                    txShift_q <= 8'hEE;
                    rdWait_q  <= 1'b0;
                end else begin
                    rdCnt_q <= rdCnt_q + RCW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (csFall) begin
                        state_q  <= HDR;
                        bitCnt_q <= 5'd31;
                        rdWait_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (csRise) begin
                        state_q  <= IDLE;
                        bitCnt_q <= 5'd31;
                    end else if (sclkRise) begin
                        rxShift_q <= rxNext;
                        bitCnt_q  <= bitCnt_q - 5'd1;
                        if (bitCnt_q == 5'd15) begin
                            state_q  <= PAD;
                            cmd_q    <= rxShift_q[15:8];
                            tileI_q  <= rxShift_q[7:5];
                            tileJ_q  <= rxShift_q[4:2];
                            opCode_q <= {rxShift_q[1:0], mosiS};
                            if (rxShift_q[15:8] == CMD_READ) begin
                                rdReq_q   <= 1'b1;
                                rdWait_q  <= 1'b1;
                                rdCnt_q   <= '0;
                                txShift_q <= '0;
                            end else if (rxShift_q[15:8] == CMD_STATUS) begin
                                txShift_q <= {6'b0, frameErr_q, done};
                            end else begin
                                txShift_q <= '0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (csRise) begin
                        state_q  <= IDLE;
                        bitCnt_q <= 5'd31;
                    end else if (sclkRise) begin
                        rxShift_q <= rxNext;
                        bitCnt_q  <= bitCnt_q - 5'd1;
                        if (bitCnt_q == 5'd8) begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclkRise) begin
                        rxShift_q <= rxNext;
                        bitCnt_q  <= bitCnt_q - 5'd1;
                        if (bitCnt_q == 5'd0) begin
                            state_q <= DONE;
                            if (cmd_q == CMD_WRITE) begin
                                wrValid_q <= 1'b1;
                                wrData_q  <= rxNext[7:0];
                            end else if (cmd_q == CMD_START) begin
                                start_q <= 1'b1;
                            end
                        end
                    end else if (csRise) begin
                        state_q  <= IDLE;
                        bitCnt_q <= 5'd31;
                    end else if (sclkFall) begin
                        miso_q    <= txShift_q[7];
                        txShift_q <= {txShift_q[6:0], 1'b0};
                    end
                end
                DONE: begin
                    // Accepting a fresh fall here keeps back-to-back frames from being lost.
                    if (csFall) begin
                        state_q  <= HDR;
                        bitCnt_q <= 5'd31;
                        rdWait_q <= 1'b0;
                    end else if (csRise) begin
                        state_q  <= IDLE;
                        bitCnt_q <= 5'd31;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    bitCnt_q <= 5'd31;
                end
            endcase
        end
    end

    assign miso      = miso_q;
    assign wr_valid  = wrValid_q;
    assign start     = start_q;
    assign rd_req    = rdReq_q;
    assign tile_i    = tileI_q;
    assign tile_j    = tileJ_q;
    assign op_code   = opCode_q;
    assign wr_data   = wrData_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Self-checking bench for spi_cmd_slave: a table of full command frames plus
// hand-written short-frame, over-long-frame and mid-frame reset sequences.
module tb_spi_cmd_slave;

    localparam int HALF = 50;
    localparam int NV   = 12;

    typedef struct {
        logic [7:0] cmd;
        logic [2:0] ti;
        logic [2:0] tj;
        logic [2:0] op;
        logic [7:0] data;
        logic       doneIn;
        logic       respond;
        logic [7:0] coreData;
        int         expWr;
        int         expStart;
        int         expRd;
        logic       expErr;
        logic [7:0] expMiso;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       wr_valid;
    logic       start;
    logic       rd_req;
    logic [2:0] tile_i;
    logic [2:0] tile_j;
    logic [2:0] op_code;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       done;
    logic       frame_err;

    int         checkCount = 0;
    int         passCount  = 0;
    int         wrCount    = 0;
    int         startCount = 0;
    int         rdCount    = 0;
    int         misoCount  = 0;
    int         widthErr   = 0;
    bit         wrPrev     = 1'b0;
    bit         startPrev  = 1'b0;
    bit         rdPrev     = 1'b0;
    logic [7:0] lastWrData = 8'h00;
    int         wrBase, startBase, rdBase, misoBase;
    logic [7:0] rxByte;
    vec_t       vecs [NV];

    spi_cmd_slave #(.SYNC_STAGES(2), .RD_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .wr_valid(wr_valid), .start(start), .rd_req(rd_req),
        .tile_i(tile_i), .tile_j(tile_j), .op_code(op_code), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and a check that no request pulse is ever wider than one clk.
    always @(negedge clk) begin
        if (wr_valid) begin
            wrCount    <= wrCount + 1;
            lastWrData <= wr_data;
        end
        if (start)  startCount <= startCount + 1;
        if (rd_req) rdCount    <= rdCount + 1;
        if (miso)   misoCount  <= misoCount + 1;
        if ((wr_valid && wrPrev) || (start && startPrev) || (rd_req && rdPrev))
            widthErr <= widthErr + 1;
        wrPrev    <= wr_valid;
        startPrev <= start;
        rdPrev    <= rd_req;
    end

    function automatic logic [31:0] makeWord(input logic [7:0] c, input logic [2:0] a,
                                             input logic [2:0] b, input logic [2:0] o,
                                             input logic [7:0] d);
        return {c, a, b, o, 7'h00, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic sendBits(input logic [31:0] word, input int nbits, input bit raiseCs,
                            output logic [7:0] got);
        got  = 8'h00;
        cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 32) ? word[31 - i] : 1'b1;
            #HALF;
            sclk = 1'b1;
            if (i >= 24 && i < 32) got = {got[6:0], miso};
            #HALF;
            sclk = 1'b0;
        end
        mosi = 1'b0;
        #HALF;
        if (raiseCs) begin
            cs_n = 1'b1;
            #HALF;
        end
    endtask

    // Core model: answers about 5 clks after rd_req, then sends a late pulse that must be ignored.
    task automatic coreRespond(input logic [7:0] d);
        int k;
        k = 0;
        while (!rd_req && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (rd_req) begin
            repeat (5) @(posedge clk);
            #1 rd_valid = 1'b1;
            rd_data = d;
            @(posedge clk);
            #1 rd_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 rd_valid = 1'b1;
            rd_data = 8'h55;
            @(posedge clk);
            #1 rd_valid = 1'b0;
            rd_data = 8'h00;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0] got;
        done      = v.doneIn;
        wrBase    = wrCount;
        startBase = startCount;
        rdBase    = rdCount;
        misoBase  = misoCount;
        fork
            sendBits(makeWord(v.cmd, v.ti, v.tj, v.op, v.data), 32, 1'b1, got);
            begin
                if (v.respond) coreRespond(v.coreData);
            end
        join
        rxByte = got;
        #50;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        rd_valid = 1'b0; rd_data = 8'h00; done = 1'b0;

        //          cmd    ti    tj    op    data   done  resp  core   wr st rd err   miso
        vecs[0]  = '{8'h01, 3'd2, 3'd5, 3'd3, 8'hA7, 1'b0, 1'b0, 8'h00, 1, 0, 0, 1'b0, 8'h00};
        vecs[1]  = '{8'h03, 3'd7, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 8'h3C, 0, 0, 1, 1'b0, 8'h3C};
        vecs[2]  = '{8'h03, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 1, 1'b1, 8'hEE};
        vecs[3]  = '{8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0, 0, 1'b0, 8'h03};
        vecs[4]  = '{8'h04, 3'd5, 3'd6, 3'd7, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1'b0, 8'h00};
        vecs[5]  = '{8'h02, 3'd4, 3'd4, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1, 0, 1'b0, 8'h00};
        vecs[6]  = '{8'h7F, 3'd3, 3'd4, 3'd1, 8'h12, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1'b1, 8'h00};
        vecs[7]  = '{8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1'b0, 8'h02};
        vecs[8]  = '{8'h01, 3'd0, 3'd7, 3'd0, 8'h5A, 1'b0, 1'b0, 8'h00, 1, 0, 0, 1'b0, 8'h00};
        vecs[9]  = '{8'h01, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b0, 1'b0, 8'h00, 1, 0, 0, 1'b0, 8'h00};
        vecs[10] = '{8'h00, 3'd1, 3'd0, 3'd1, 8'h33, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1'b1, 8'h00};
        vecs[11] = '{8'h04, 3'd2, 3'd2, 3'd2, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0, 0, 1'b0, 8'h03};

        #23;
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset miso", 32'(miso), 32'd0);
        checkOutput("reset pulses", 32'({wr_valid, start, rd_req}), 32'd0);
        checkOutput("reset tile/op", 32'({tile_i, tile_j, op_code}), 32'd0);
        checkOutput("reset wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        #50;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d wr_valid pulses", i), wrCount - wrBase, vecs[i].expWr);
            checkOutput($sformatf("v%0d start pulses", i), startCount - startBase, vecs[i].expStart);
            checkOutput($sformatf("v%0d rd_req pulses", i), rdCount - rdBase, vecs[i].expRd);
            checkOutput($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].expErr));
            checkOutput($sformatf("v%0d tile_i", i), 32'(tile_i), 32'(vecs[i].ti));
            checkOutput($sformatf("v%0d tile_j", i), 32'(tile_j), 32'(vecs[i].tj));
            checkOutput($sformatf("v%0d op_code", i), 32'(op_code), 32'(vecs[i].op));
            checkOutput($sformatf("v%0d miso byte", i), 32'(rxByte), 32'(vecs[i].expMiso));
            if (vecs[i].expWr != 0)
                checkOutput($sformatf("v%0d wr_data", i), 32'(lastWrData), 32'(vecs[i].data));
            if (vecs[i].expMiso == 8'h00)
                checkOutput($sformatf("v%0d miso idle", i), misoCount - misoBase, 32'd0);
        end

        // Short WRITE frame aborted after 20 bits, then a full START frame.
        wrBase = wrCount;
        sendBits(makeWord(8'h01, 3'd2, 3'd5, 3'd3, 8'hA7), 20, 1'b1, rxByte);
        #50;
        checkOutput("short wr_valid pulses", wrCount - wrBase, 32'd0);
        checkOutput("short frame_err", 32'(frame_err), 32'd1);
        startBase = startCount;
        sendBits(makeWord(8'h02, 3'd6, 3'd5, 3'd4, 8'h00), 32, 1'b1, rxByte);
        #50;
        checkOutput("after-short start pulses", startCount - startBase, 32'd1);
        checkOutput("after-short tile_i", 32'(tile_i), 32'd6);
        checkOutput("after-short frame_err sticky", 32'(frame_err), 32'd1);

        // Over-long frame: extra bits while cs_n stays low are ignored.
        wrBase = wrCount;
        sendBits(makeWord(8'h01, 3'd6, 3'd1, 3'd2, 8'hC3), 40, 1'b1, rxByte);
        #50;
        checkOutput("long wr_valid pulses", wrCount - wrBase, 32'd1);
        checkOutput("long wr_data", 32'(lastWrData), 32'hC3);
        checkOutput("long tile_j", 32'(tile_j), 32'd1);

        // Reset in the middle of a WRITE frame, then a 64-frame back-to-back burst.
        wrBase = wrCount;
        sendBits(makeWord(8'h01, 3'd1, 3'd2, 3'd3, 8'h99), 22, 1'b0, rxByte);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        #30;
        checkOutput("midreset frame_err", 32'(frame_err), 32'd0);
        checkOutput("midreset tile_i", 32'(tile_i), 32'd0);
        checkOutput("midreset wr_data", 32'(wr_data), 32'd0);
        checkOutput("midreset miso", 32'(miso), 32'd0);
        #20;
        rst_n = 1'b1;
        #50;
        checkOutput("aborted frame wr_valid pulses", wrCount - wrBase, 32'd0);

        wrBase = wrCount;
        for (int n = 0; n < 64; n++) begin
            sendBits(makeWord(8'h01, 3'(n), 3'(n >> 3), 3'(n + 1), 8'(n * 3 + 1)), 32, 1'b1, rxByte);
        end
        #50;
        checkOutput("burst wr_valid pulses", wrCount - wrBase, 32'd64);
        checkOutput("burst last wr_data", 32'(wr_data), 32'hBE);
        checkOutput("burst last tile", 32'({tile_i, tile_j, op_code}), 32'({3'd7, 3'd7, 3'd0}));
        checkOutput("burst frame_err", 32'(frame_err), 32'd0);
        checkOutput("pulse width violations", widthErr, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
